// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard controller: stalls PC and IF/ID, bubbles ID/EX, flushes IF/ID on taken branch.
// Stall outputs are combinational (0-cycle) from inputs and state; multi-cycle stalls are held by an internal counter.
module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int LOAD_LAT     = 1,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_rt_used,
  input  logic             ifid_branch,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_zero,
  output logic             ifid_flush,
  output logic             stall_active,
  output logic [3:0]       stall_cnt
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
    $error("hazard_ctrl: LOAD_LAT must be in 1..15");
  end

  localparam logic [4:0] LAT_LOAD   = 5'(LOAD_LAT);
  localparam logic [4:0] LAT_BRLOAD = 5'(LOAD_LAT + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       match;
  logic       load_haz;
  logic       br_haz;
  logic [4:0] stall_len;

  // Stall length of the hazard seen this cycle; 0 means no hazard.
  always_comb begin
    match     = (idex_rd != '0) &&
                ((idex_rd == ifid_rs) || (ifid_rt_used && (idex_rd == ifid_rt)));
    load_haz  = idex_mem_read && match;
    br_haz    = BRANCH_IN_ID && ifid_branch && match && (idex_reg_write || idex_mem_read);
    stall_len = 5'd0;
    if (br_haz && idex_mem_read) begin
      stall_len = LAT_BRLOAD;
    end else if (br_haz) begin
      stall_len = 5'd1;
    end else if (load_haz) begin
      stall_len = LAT_LOAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_zero  = 1'b0;
    ifid_flush = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_zero  = 1'b1;
      state_d    = IDLE;
      cnt_d      = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (stall_len != 5'd0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_zero  = 1'b1;
            if (stall_len > 5'd1) begin
              state_d = STALL;
              cnt_d   = 4'(stall_len - 5'd1);
            end
          end else begin
            ifid_flush = BRANCH_IN_ID && ifid_branch && branch_taken;
          end
        end
        STALL: begin
          // Detection is masked here: the bubble already altered ID/EX.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_zero  = 1'b1;
          if (cnt_q == 4'd1) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_active = (state_q == STALL);
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: several parameter builds share one stimulus stream; each is checked
// against a per-build model that tracks only "stall cycles still owed".
module tb_hazard_ctrl;

  localparam int NI = 6;

  function automatic int lat_of(int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 4;
      4:       return 15;
      default: return 3;
    endcase
  endfunction

  function automatic bit bid_of(int i);
    return (i != 5);
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_mem_read, idex_reg_write, ifid_rt_used, ifid_branch, branch_taken;
  logic [4:0] idex_rd, ifid_rs, ifid_rt;

  logic       pc_write_o   [NI];
  logic       ifid_write_o [NI];
  logic       idex_zero_o  [NI];
  logic       ifid_flush_o [NI];
  logic       stall_act_o  [NI];
  logic [3:0] stall_cnt_o  [NI];

  int rem [NI];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_ctrl #(
      .REG_W       (5),
      .LOAD_LAT    (lat_of(g)),
      .BRANCH_IN_ID(bid_of(g))
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .idex_mem_read (idex_mem_read),
      .idex_reg_write(idex_reg_write),
      .idex_rd       (idex_rd),
      .ifid_rs       (ifid_rs),
      .ifid_rt       (ifid_rt),
      .ifid_rt_used  (ifid_rt_used),
      .ifid_branch   (ifid_branch),
      .branch_taken  (branch_taken),
      .pc_write      (pc_write_o[g]),
      .ifid_write    (ifid_write_o[g]),
      .idex_zero     (idex_zero_o[g]),
      .ifid_flush    (ifid_flush_o[g]),
      .stall_active  (stall_act_o[g]),
      .stall_cnt     (stall_cnt_o[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stall cycles a hazard costs in an idle controller, straight from the hazard rules.
  function automatic int need(int lat, bit bid);
    bit m;
    m = (idex_rd != 0) && ((idex_rd == ifid_rs) || (ifid_rt_used && (idex_rd == ifid_rt)));
    if (bid && ifid_branch && m && idex_mem_read)  return lat + 1;
    if (bid && ifid_branch && m && idex_reg_write) return 1;
    if (idex_mem_read && m)                        return lat;
    return 0;
  endfunction

  task automatic set_in(input bit mr, input bit rw, input int rd, input int rs, input int rt,
                        input bit rtu, input bit br, input bit tk);
    idex_mem_read  = mr;
    idex_reg_write = rw;
    idex_rd        = 5'(rd);
    ifid_rs        = 5'(rs);
    ifid_rt        = 5'(rt);
    ifid_rt_used   = rtu;
    ifid_branch    = br;
    branch_taken   = tk;
  endtask

  task automatic clear_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Check every build at the falling edge, advance the models, return just after the next rising edge.
  task automatic cyc();
    int n;
    bit stall, flush;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("stall_active[%0d]", i), int'(stall_act_o[i]), int'(rem[i] > 0));
      chk($sformatf("stall_cnt[%0d]", i), int'(stall_cnt_o[i]), rem[i]);
      flush = 1'b0;
      if (rst) begin
        stall  = 1'b1;
        rem[i] = 0;
      end else if (rem[i] > 0) begin
        stall  = 1'b1;
        rem[i] = rem[i] - 1;
      end else begin
        n = need(lat_of(i), bid_of(i));
        stall = (n > 0);
        if (stall) rem[i] = n - 1;
        else       flush = bid_of(i) && ifid_branch && branch_taken;
      end
      chk($sformatf("pc_write[%0d]", i), int'(pc_write_o[i]), int'(!stall));
      chk($sformatf("ifid_write[%0d]", i), int'(ifid_write_o[i]), int'(!stall));
      chk($sformatf("idex_zero[%0d]", i), int'(idex_zero_o[i]), int'(stall));
      chk($sformatf("ifid_flush[%0d]", i), int'(ifid_flush_o[i]), int'(flush));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clear_in();
    repeat (17) cyc();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    for (int i = 0; i < NI; i++) rem[i] = 0;
    @(posedge clk);
    #1;
    // reset held, then released with no hazard
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    // load-use on rs, input dropped after one cycle
    set_in(1, 1, 1, 1, 0, 0, 0, 0);
    cyc();
    drain();
    // register 0 never hazards
    set_in(1, 1, 0, 0, 0, 1, 0, 0);
    repeat (2) cyc();
    // load-use on rt, used and unused
    set_in(1, 1, 2, 5, 2, 1, 0, 0);
    cyc();
    drain();
    set_in(1, 1, 2, 5, 2, 0, 0, 0);
    cyc();
    drain();
    // branch after ALU producer, then after load
    set_in(0, 1, 4, 4, 0, 0, 1, 0);
    cyc();
    drain();
    set_in(1, 1, 4, 4, 0, 0, 1, 0);
    cyc();
    drain();
    // taken branch without and with a hazard
    set_in(0, 0, 0, 4, 0, 0, 1, 1);
    cyc();
    clear_in();
    cyc();
    set_in(0, 1, 4, 4, 0, 0, 1, 1);
    cyc();
    drain();
    // reset in the second stall cycle
    set_in(1, 1, 3, 3, 0, 0, 0, 0);
    cyc();
    clear_in();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    // random traffic over a small register range so hazards are frequent
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
